// File: rtl/mbe_pp_accum_if.sv
// Handshake bundle for the digit-serial Booth partial-product accumulator:
// start/multiplicand, the Booth digit stream, and the product return channel.
interface mbe_pp_accum_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     y;
  logic                 dig_valid;
  logic                 dig_ready;
  logic                 single;
  logic                 double;
  logic                 neg;
  logic                 p_valid;
  logic                 p_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;
  logic                 err;

  // Producer side: the Booth encoder plus the product consumer.
  modport master (
    output start, y, dig_valid, single, double, neg, p_ready,
    input  dig_ready, p_valid, p, busy, err
  );

  // The accumulator itself.
  modport slave (
    input  start, y, dig_valid, single, double, neg, p_ready,
    output dig_ready, p_valid, p, busy, err
  );
endinterface

// File: rtl/mbe_pp_accum.sv
// Radix-4 modified Booth partial-product accumulator: latches a signed
// multiplicand, sums one shifted partial product per accepted digit (LSB digit
// first) and returns the signed product over a valid/ready handshake.
// Optional illegal-digit flag enabled by defining MBE_PP_ACCUM_CHECK_EN.
module mbe_pp_accum #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 2
) (
  input logic           clk,
  input logic           reset,
  mbe_pp_accum_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_yreg;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_p;
  logic [KW-1:0]   r_k;

  logic            w_load;
  logic            w_accept;
  logic            w_last;
  logic [PW-1:0]   w_yext;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_sum;

  assign w_last = (r_k == KW'(DIGITS - 1));

  // Single wins over double, so an illegal single+double digit selects 1*y.
  assign w_yext = {{WIDTH{r_yreg[WIDTH-1]}}, r_yreg};
  assign w_sel  = bus.single ? w_yext :
                  bus.double ? (w_yext << 1) :
                               '0;
  assign w_pp   = bus.neg ? (~w_sel + PW'(1)) : w_sel;
  assign w_sum  = r_acc + (w_pp << {r_k, 1'b0});

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.dig_valid) begin
          w_accept = 1'b1;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.p_ready) begin
          if (bus.start) begin
            w_load      = 1'b1;
            w_state_nxt = S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_yreg  <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_yreg <= bus.y;
        r_acc  <= '0;
        r_k    <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_k   <= r_k + KW'(1);
        if (w_last) r_p <= w_sum;
      end
    end
  end

`ifdef MBE_PP_ACCUM_CHECK_EN
  logic r_err;

  // Sticky until the next accepted start, so it is still visible with p_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_load) begin
      r_err <= 1'b0;
    end else if (w_accept && bus.single && bus.double) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.dig_ready = (r_state == S_ACCUM);
  assign bus.p_valid   = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.p         = r_p;

endmodule

// File: tb/tb_mbe_pp_accum.sv
// Directed bench for mbe_pp_accum: a table of multiplicand/digit-stream
// vectors plus hand-written stall, back-to-back, reset and illegal-digit runs.
module tb_mbe_pp_accum;

  localparam int W = 8;
  localparam int D = W / 2;

  // Booth digit codes, {single, double, neg}
  localparam logic [2:0] SP  = 3'b100;
  localparam logic [2:0] SN  = 3'b101;
  localparam logic [2:0] DP  = 3'b010;
  localparam logic [2:0] DN  = 3'b011;
  localparam logic [2:0] Z   = 3'b000;
  localparam logic [2:0] ZN  = 3'b001;
  localparam logic [2:0] ILL = 3'b110;

  localparam logic [3*D-1:0] X05 = {Z, Z, SP, SP};
  localparam logic [3*D-1:0] XFF = {ZN, ZN, ZN, SN};
  localparam logic [3*D-1:0] X80 = {DN, Z, Z, Z};
  localparam logic [3*D-1:0] X7F = {DP, ZN, ZN, SN};

`ifdef MBE_PP_ACCUM_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    string          name;
    logic [W-1:0]   y;
    logic [3*D-1:0] digs;
    logic [2*W-1:0] exp_p;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mbe_pp_accum_if #(.WIDTH(W)) bus ();

  mbe_pp_accum #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] y);
    bus.start = 1'b1;
    bus.y     = y;
    tick();
    bus.start = 1'b0;
    check("accum_entry_ready", 32'(bus.dig_ready), 32'd1);
  endtask

  task automatic put_digit(input logic [2:0] d);
    {bus.single, bus.double, bus.neg} = d;
    bus.dig_valid = 1'b1;
    tick();
    bus.dig_valid = 1'b0;
    {bus.single, bus.double, bus.neg} = 3'b000;
  endtask

  // Feeds all digits with `gap` idle cycles before each one after the first;
  // optionally pulses start (with a different y) during the first gap.
  task automatic feed(input logic [3*D-1:0] digs, input int gap, input bit mid_start);
    for (int i = 0; i < D; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          if (mid_start && i == 1 && g == 0) begin
            bus.start = 1'b1;
            bus.y     = 8'h55;
          end
          tick();
          bus.start = 1'b0;
          check("gap_ready_held", 32'(bus.dig_ready), 32'd1);
        end
      end
      put_digit(digs[3*i +: 3]);
      if (i < D - 1) check("p_valid_early", 32'(bus.p_valid), 32'd0);
      else begin
        check("p_valid_on_time", 32'(bus.p_valid), 32'd1);
        check("done_not_ready", 32'(bus.dig_ready), 32'd0);
      end
    end
  endtask

  // Holds p_ready low for `hold` cycles, then hands off the product.
  task automatic release_p(input int hold, input logic [2*W-1:0] exp_p);
    for (int h = 0; h < hold; h++) begin
      bus.p_ready = 1'b0;
      check("hold_p_valid", 32'(bus.p_valid), 32'd1);
      check("hold_p_stable", 32'(bus.p), 32'(exp_p));
      tick();
    end
    bus.p_ready = 1'b1;
    check("handoff_p_valid", 32'(bus.p_valid), 32'd1);
    tick();
    bus.p_ready = 1'b0;
    check("after_handoff_valid", 32'(bus.p_valid), 32'd0);
    check("after_handoff_busy", 32'(bus.busy), 32'd0);
    check("after_handoff_p_kept", 32'(bus.p), 32'(exp_p));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dig_ready"}, 32'(bus.dig_ready), 32'd0);
    check({tag, "_p_valid"}, 32'(bus.p_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_p"}, 32'(bus.p), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"y07_x05", 8'h07, X05, 16'h0023};
    vecs[1] = '{"yFD_xFF", 8'hFD, XFF, 16'h0003};
    vecs[2] = '{"y80_x80", 8'h80, X80, 16'h4000};
    vecs[3] = '{"y7F_x7F", 8'h7F, X7F, 16'h3F01};
    vecs[4] = '{"yFD_x05", 8'hFD, X05, 16'hFFF1};
    vecs[5] = '{"y80_x7F", 8'h80, X7F, 16'hC080};
    vecs[6] = '{"y7F_x80", 8'h7F, X80, 16'hC080};
    vecs[7] = '{"y00_xFF", 8'h00, XFF, 16'h0000};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.y         = '0;
    bus.dig_valid = 1'b0;
    bus.single    = 1'b0;
    bus.double    = 1'b0;
    bus.neg       = 1'b0;
    bus.p_ready   = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      do_start(vecs[v].y);
      feed(vecs[v].digs, 0, 1'b0);
      check({vecs[v].name, "_p"}, 32'(bus.p), 32'(vecs[v].exp_p));
      check({vecs[v].name, "_err"}, 32'(bus.err), 32'd0);
      release_p(0, vecs[v].exp_p);
    end

    // Digit gaps, a start pulse inside ACCUM, and a stalled handoff.
    do_start(8'h07);
    feed(X05, 2, 1'b1);
    check("stall_p", 32'(bus.p), 32'h0023);
    release_p(3, 16'h0023);

    // Start coincident with p_ready: no IDLE bubble.
    do_start(8'h07);
    feed(X05, 0, 1'b0);
    check("b2b_first_p", 32'(bus.p), 32'h0023);
    bus.p_ready = 1'b1;
    bus.start   = 1'b1;
    bus.y       = 8'h7F;
    tick();
    bus.p_ready = 1'b0;
    bus.start   = 1'b0;
    check("b2b_valid_dropped", 32'(bus.p_valid), 32'd0);
    check("b2b_ready", 32'(bus.dig_ready), 32'd1);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    feed(X7F, 0, 1'b0);
    check("b2b_second_p", 32'(bus.p), 32'h3F01);
    release_p(0, 16'h3F01);

    // Reset after two of four digits discards the partial result.
    do_start(8'h07);
    put_digit(SP);
    put_digit(SP);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("mid_reset");
    do_start(8'h07);
    feed(X05, 0, 1'b0);
    check("post_reset_p", 32'(bus.p), 32'h0023);
    release_p(0, 16'h0023);

    // Illegal digit acts as +1*y; err depends on the build.
    do_start(8'h07);
    feed({Z, Z, SP, ILL}, 0, 1'b0);
    check("illegal_p", 32'(bus.p), 32'h0023);
    check("illegal_err_done", 32'(bus.err), 32'(EXP_ERR));
    release_p(1, 16'h0023);
    check("illegal_err_idle", 32'(bus.err), 32'(EXP_ERR));
    do_start(8'h05);
    check("err_cleared_by_start", 32'(bus.err), 32'd0);
    feed(X05, 0, 1'b0);
    check("after_err_p", 32'(bus.p), 32'h0019);
    release_p(0, 16'h0019);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mbe_pp_accum.md
Name: mbe_pp_accum

Overview:
- Consumer side of the radix-4 modified Booth encoder: takes encoded digits (single, double, neg), one per handshake, LSB digit first.
- Selects the matching partial product of a latched signed multiplicand and accumulates it at the correct shift.
- Returns the full signed product through a valid/ready output handshake.
- Sits between the Booth encoder stage and downstream datapath consumers, forming a digit-serial signed multiplier.

Parameters:
- WIDTH, 8, multiplicand width in bits; must be even and >= 4.
- DIGITS, WIDTH/2, Booth digits per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin operation; samples y.
- y  input  WIDTH  signed two's-complement multiplicand.
- dig_valid  input  1  digit present on single/double/neg.
- dig_ready  output  1  block accepts a digit this cycle.
- single  input  1  Booth digit magnitude is 1.
- double  input  1  Booth digit magnitude is 2.
- neg  input  1  Booth digit sign; 1 = negative.
- p_valid  output  1  product valid.
- p_ready  input  1  downstream accepts product.
- p  output  2*WIDTH  signed product.
- busy  output  1  high in ACCUM or DONE.
- err  output  1  sticky illegal-digit flag.

Behaviour:
- Reset is synchronous and active-high, sampled on rising clk. Reset values:
  - state = IDLE; acc, p, and digit index k = 0.
  - dig_ready, p_valid, busy, and err = 0.
  - Reset has priority over every other input, including mid-ACCUM and mid-DONE; any partial result is discarded and not presented.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - dig_ready = 0; p_valid = 0.
  - start = 1: latch y into yreg, acc <= 0, k <= 0, err <= 0, go to ACCUM.
- ACCUM:
  - dig_ready = 1.
  - Digit accepted when dig_valid & dig_ready.
  - Selection: sel = single ? yreg : double ? (yreg << 1) : 0, sign-extended to 2*WIDTH. pp = neg ? -sel : sel. neg with a zero magnitude yields 0.
  - On accept: acc <= acc + (pp << 2k), modulo 2^(2*WIDTH); k <= k+1.
  - When the accepted digit has k = DIGITS-1: p <= final sum, go to DONE.
  - dig_valid = 0 holds state; any number of idle cycles is allowed.
  - start is ignored.
- DONE:
  - p_valid = 1; dig_ready = 0; p stable until p_ready.
  - p_ready = 1 and start = 0: go to IDLE, p_valid drops next cycle, p retains its value.
  - p_ready = 1 and start = 1: product handed off and new operation begins (latch y, clear acc/k/err, go to ACCUM). Back-to-back, no bubble.
  - start without p_ready: ignored.
- busy = (state != IDLE).
- Latency: start at cycle N; with dig_valid held high, digits are accepted N+1..N+DIGITS and p_valid is asserted in cycle N+DIGITS+1.
- Result is exact for all signed y and all digit streams produced by the encoder from a signed WIDTH-bit multiplier.
- Illegal digit (single = double = 1): treated as single (single has priority).

Optional Feature:
- Macro: MBE_PP_ACCUM_CHECK_EN.
- Defined: accepting a digit with single & double sets err = 1. err is sticky until the next accepted start or reset, and is visible alongside p_valid.
- Not defined: no check logic; err tied to 0. Illegal-digit datapath behaviour is unchanged.

Test Plan:
- Reset, then start with y = 8'h07; digits for x = 8'h05 (010 single+, 010 single+, 000, 000) with dig_valid held -> p_valid at N+5, p = 16'h0023, err = 0.
- y = 8'hFD (-3); digits for x = 8'hFF (single neg, then three zero-neg digits) -> p = 16'h0003.
- y = 8'h80 (-128); digits for x = 8'h80 (three zero, then double neg) -> p = 16'h4000. y = 8'h7F with x = 8'h7F -> p = 16'h3F01.
- Stalls: y = 8'h07, x = 8'h05 digits with dig_valid low for 2 cycles between each digit, and p_ready low 3 cycles after p_valid -> p = 16'h0023 held stable, p_valid held for 4 cycles. Start pulsed mid-ACCUM -> ignored. Start together with p_ready in DONE -> next op begins with no IDLE cycle.
- Reset asserted after 2 of 4 digits -> next cycle all outputs at reset values. A fresh op with y = 8'h07, x = 8'h05 -> p = 16'h0023.
- With MBE_PP_ACCUM_CHECK_EN: one digit with single = double = 1 -> err = 1 through DONE, cleared by next start. Without the macro -> err stays 0, same p.
